spi_slave: RTL and testbench
============================

# spi_slave

Serial front end of the SPI memory slave. Deserializes MOSI frames under SS_n into 10-bit command words for the downstream RAM (rx_data/rx_valid) and serializes the RAM's 8-bit read data (tx_data/tx_valid) back out on MISO. It owns the frame FSM and tracks whether a read address has been loaded.

## Interface
- DATA_WIDTH, 8: read-data width returned on MISO.
- FRAME_BITS, 10: command-word width (2-bit opcode + DATA_WIDTH payload).
- clk  in  1  system clock; all sampling on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select, active low; frame boundary.
- MOSI  in  1  serial data in, MSB first.
- tx_data  in  DATA_WIDTH  read data from RAM.
- tx_valid  in  1  RAM read data valid (level; may stay high).
- rx_data  out  FRAME_BITS  assembled command word {opcode[1:0], payload[7:0]}.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- MISO  out  1  serial read data out, MSB first.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD.
- CHK_CMD samples MOSI as command bit: 0 -> WRITE; 1 with rd_addr_held=0 -> READ_ADD; 1 with rd_addr_held=1 -> READ_DATA. SS_n=1 -> IDLE.
- WRITE/READ_ADD/READ_DATA: shift MOSI into rx_shift LSB each cycle SS_n=0; bit_cnt 0..10. On the 10th bit: rx_data <= frame, rx_valid=1 next cycle for exactly one cycle.
- rd_addr_held: set on completed READ_ADD frame, cleared on completed READ_DATA frame; unchanged on WRITE or aborted frames.
- READ_DATA after rx_valid: wait for tx_valid; capture tx_data on first tx_valid=1 seen in wait phase only (loaded flag blocks re-capture of a level-held tx_valid). Then 8 MISO bits, tx_data[7] first.
- After 8th bit, or outside transmit phase: MISO=0. Remain in current state until SS_n=1 -> IDLE.
- Extra MOSI bits after frame completion ignored.
- Opcode bits are forwarded as received (see Configuration).

## Timing
- Reset (async assert, sync deassert by posedge): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit_cnt=0, rd_addr_held=0, loaded=0.
- Frame: SS_n falls at cycle 0 (IDLE sees it), CHK_CMD at cycle 1 samples command bit, data bits sampled cycles 2..11, rx_valid high in cycle 12.
- MISO: tx_valid sampled high in cycle N -> MISO = bit7 in N+1 ... bit0 in N+8; MISO = 0 from N+9.
- SS_n=1 at any posedge: state -> IDLE next cycle, bit_cnt cleared, partial frame discarded (no rx_valid), MISO=0, loaded cleared.
- SS_n=1 in the same cycle as the 10th bit: frame discarded.
- Reset mid-frame or mid-transmit: immediate return to reset values; rd_addr_held cleared.
- rx_valid never high on two consecutive cycles.

## Configuration
- SPI_OPCODE_CHECK_EN defined: completed frame dropped (no rx_valid, rd_addr_held unchanged, no MISO transmit) when opcode mismatches path: WRITE requires rx[9]=0, READ_ADD requires 2'b10, READ_DATA requires 2'b11.
- Undefined: all completed frames forwarded unchanged; path state updates regardless of opcode.

## Structure
- Package spi_pkg: state_e enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA); opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11; FRAME_BITS default.
- One sub-module: spi_tx_ser (load/shift 8-bit MISO serializer with done flag). FSM and rx shifter inline.

## Test plan
- Write address: SS_n low, MOSI 0 then 00_1010_0101 -> rx_valid one cycle later with rx_data=10'h0A5, MISO=0 throughout.
- Read address then read data: frame 1 + 10_0000_0011 -> rx_data=10'h203, rd_addr_held=1; next frame 1 + 11_xxxx_xxxx -> rx_data[9:8]=11, RAM returns tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on consecutive cycles, rd_addr_held=0.
- Held tx_valid: tx_valid stays high 20 cycles after capture -> MISO sends 8'hC3 once, then 0.
- Abort: SS_n rises after 5 data bits -> no rx_valid, IDLE next cycle, rd_addr_held unchanged.
- Async reset mid-transmit (after 3 MISO bits) -> MISO=0, rx_valid=0, state IDLE immediately, rd_addr_held=0.
- With SPI_OPCODE_CHECK_EN: WRITE path frame 11_0000_0001 -> no rx_valid; without macro -> rx_valid with rx_data=10'h301.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory-slave front end.
// Frame FSM state encoding, command opcodes and the opcode/path legality check.
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int FRAME_BITS_DEF = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // True when the received opcode matches the path chosen by the command bit.
  function automatic logic opcode_ok(input state_e st, input logic [1:0] op);
    case (st)
      WRITE:     opcode_ok = (op == OP_WR_ADDR) || (op == OP_WR_DATA);
      READ_ADD:  opcode_ok = (op == OP_RD_ADDR);
      READ_DATA: opcode_ok = (op == OP_RD_DATA);
      default:   opcode_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_tx_ser.sv
// Load/shift MISO serializer: W bits MSB first, line held low when idle.
// done rises once the final bit has left the line and stays until the next load/clr.
module spi_tx_ser #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         miso,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          miso_q, miso_d;
  logic          done_q, done_d;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    miso_d = 1'b0;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load) begin
      sh_d   = data << 1;
      miso_d = data[W-1];
      cnt_d  = CW'(W - 1);
      done_d = 1'b0;
    end else if (cnt_q != '0) begin
      miso_d = sh_q[W-1];
      sh_d   = sh_q << 1;
      cnt_d  = cnt_q - 1'b1;
    end else begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      miso_q <= miso_d;
      done_q <= done_d;
    end
  end

  assign miso = miso_q;
  assign done = done_q;

endmodule

// File: rtl/spi_slave.sv
// SPI memory-slave serial front end: frame FSM, MOSI deserializer, MISO read-back.
// Optional macro SPI_OPCODE_CHECK_EN drops completed frames whose opcode does not fit the path.
//
// state     | meaning
// IDLE      | waiting for SS_n low
// CHK_CMD   | sampling the command bit that selects the path
// WRITE     | receiving a write frame
// READ_ADD  | receiving a read-address frame
// READ_DATA | receiving a read-data frame, then returning RAM data on MISO
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  MISO
);

  localparam int               CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-2:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rd_addr_held_q, rd_addr_held_d;
  logic                  loaded_q, loaded_d;
  logic                  frame_ok_q, frame_ok_d;

  logic [FRAME_BITS-1:0] frame;
  logic                  frame_accept;
  logic                  tx_load, tx_clr, tx_miso, tx_done;

  assign frame = {rx_shift_q, MOSI};

`ifdef SPI_OPCODE_CHECK_EN
  assign frame_accept = opcode_ok(state_q, frame[FRAME_BITS-1 -: 2]);
`else
  assign frame_accept = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_held_d = rd_addr_held_q;
    loaded_d       = loaded_q;
    frame_ok_d     = frame_ok_q;
    tx_load        = 1'b0;
    tx_clr         = 1'b0;
    if (SS_n) begin
      // Frame boundary: anything partial is discarded and the line is released.
      state_d    = IDLE;
      bit_cnt_d  = '0;
      loaded_d   = 1'b0;
      frame_ok_d = 1'b0;
      tx_clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_held_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_q != CNT_FULL) begin
            rx_shift_d = frame[FRAME_BITS-2:0];
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_LAST && frame_accept) begin
              rx_data_d  = frame;
              rx_valid_d = 1'b1;
              frame_ok_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_held_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_held_d = 1'b0;
            end
          end
          // loaded blocks a level-held tx_valid from restarting the serializer.
          if (state_q == READ_DATA && frame_ok_q && !loaded_q && tx_valid) begin
            tx_load  = 1'b1;
            loaded_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_held_q <= 1'b0;
      loaded_q       <= 1'b0;
      frame_ok_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_held_q <= rd_addr_held_d;
      loaded_q       <= loaded_d;
      frame_ok_q     <= frame_ok_d;
    end
  end

  spi_tx_ser #(.W(DATA_WIDTH)) u_tx_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tx_clr),
    .load  (tx_load),
    .data  (tx_data),
    .miso  (tx_miso),
    .done  (tx_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign MISO     = tx_miso & ~tx_done;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: per-cycle comparison of rx_valid/rx_data/MISO against a frame-level model.
// The model tracks only the read-address-held flag and derives each frame's expected timeline.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       MISO;

  int errors = 0;
  int checks = 0;
  bit held_m = 1'b0;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .MISO     (MISO)
  );

  // path: 0 write, 1 read-address, 2 read-data
  function automatic bit op_ok(input int path, input logic [1:0] op);
`ifdef SPI_OPCODE_CHECK_EN
    if (path == 0) return op[1] == 1'b0;
    if (path == 1) return op == 2'b10;
    return op == 2'b11;
`else
    return 1'b1;
`endif
  endfunction

  // One SS_n-low frame. Iteration c samples the outputs of cycle c, then drives the inputs of cycle c.
  task automatic run_frame(input string name, input logic cmd, input logic [9:0] word,
                           input int nbits, input logic [7:0] txb, input int tx_start,
                           input int tx_len, input int rst_at);
    bit exp_rv[128];
    bit exp_miso[128];
    int path, last, t;
    bit acc;
    for (int i = 0; i < 128; i++) begin
      exp_rv[i]   = 1'b0;
      exp_miso[i] = 1'b0;
    end
    path = (cmd == 1'b0) ? 0 : (held_m ? 2 : 1);
    acc  = (nbits == 10) && op_ok(path, word[9:8]);
    last = (nbits == 10) ? (((tx_start + tx_len > 14) ? tx_start + tx_len : 14) + 10) : 2 + nbits;
    if (acc) exp_rv[12] = 1'b1;
    t = (tx_start > 12) ? tx_start : 12;
    if (acc && path == 2 && tx_len > 0 && t < tx_start + tx_len)
      for (int i = 0; i < 8; i++) exp_miso[t + 1 + i] = txb[7 - i];

    for (int c = 0; c <= last + 2; c++) begin
      @(negedge clk);
      checks++;
      if (rx_valid !== exp_rv[c]) begin
        errors++;
        $display("FAIL %s rx_valid cyc=%0d got=%b exp=%b", name, c, rx_valid, exp_rv[c]);
      end
      if (exp_rv[c]) begin
        checks++;
        if (rx_data !== word) begin
          errors++;
          $display("FAIL %s rx_data got=%h exp=%h", name, rx_data, word);
        end
      end
      checks++;
      if (MISO !== exp_miso[c]) begin
        errors++;
        $display("FAIL %s MISO cyc=%0d got=%b exp=%b", name, c, MISO, exp_miso[c]);
      end
      if (nbits < 10 && c == 3 + nbits) begin
        checks++;
        if (dut.state_q !== IDLE) begin
          errors++;
          $display("FAIL %s abort_state got=%0d exp=%0d", name, dut.state_q, IDLE);
        end
      end

      SS_n = (c >= last) ? 1'b1 : 1'b0;
      if (c == 1)                       MOSI = cmd;
      else if (c >= 2 && c < 2 + nbits) MOSI = word[11 - c];
      else                              MOSI = 1'($urandom);
      tx_valid = (c >= tx_start) && (c < tx_start + tx_len);
      tx_data  = tx_valid ? txb : 8'($urandom);

      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
          errors++;
          $display("FAIL %s async_reset got miso=%b rv=%b rd=%h exp 0/0/000", name, MISO, rx_valid, rx_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
          errors++;
          $display("FAIL %s reset_state got=%0d exp=%0d", name, dut.state_q, IDLE);
        end
        @(negedge clk);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        held_m   = 1'b0;
        return;
      end
    end
    tx_valid = 1'b0;
    if (acc && path == 1) held_m = 1'b1;
    if (acc && path == 2) held_m = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (rx_valid !== 1'b0 || MISO !== 1'b0 || rx_data !== 10'h000) begin
      errors++;
      $display("FAIL reset_outputs got rv=%b miso=%b rd=%h exp 0/0/000", rx_valid, MISO, rx_data);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    run_frame("wr_addr", 1'b0, 10'h0A5, 10, 8'h77, 14, 3, -1);
    run_frame("wr_data", 1'b0, 10'h15A, 10, 8'h11, 13, 1, -1);
  endtask

  task automatic test_read();
    run_frame("rd_addr", 1'b1, 10'h203, 10, 8'h00, 0, 0, -1);
    run_frame("rd_data", 1'b1, {2'b11, 8'($urandom)}, 10, 8'hC3, 15, 1, -1);
    run_frame("rd_addr_again", 1'b1, 10'h2F0, 10, 8'h99, 14, 2, -1);
    run_frame("rd_data_again", 1'b1, 10'h3AA, 10, 8'h5A, 12, 1, -1);
  endtask

  task automatic test_held_tx();
    run_frame("held_addr", 1'b1, 10'h210, 10, 8'h00, 0, 0, -1);
    run_frame("held_data", 1'b1, 10'h3FF, 10, 8'hC3, 13, 20, -1);
  endtask

  task automatic test_abort();
    run_frame("abort_addr", 1'b1, 10'h244, 10, 8'h00, 0, 0, -1);
    run_frame("abort_5", 1'b1, 10'h3C3, 5, 8'h00, 0, 0, -1);
    run_frame("abort_9", 1'b1, 10'h3C3, 9, 8'h00, 0, 0, -1);
    run_frame("after_abort", 1'b1, 10'h381, 10, 8'hA6, 16, 4, -1);
  endtask

  task automatic test_opcode();
    run_frame("wr_opcode11", 1'b0, 10'h301, 10, 8'h00, 0, 0, -1);
    run_frame("ra_opcode00", 1'b1, 10'h0AB, 10, 8'h00, 0, 0, -1);
    run_frame("rd_opcode01", 1'b1, 10'h1CD, 10, 8'h3C, 14, 2, -1);
  endtask

  task automatic test_reset_mid_tx();
    run_frame("rst_addr", 1'b1, 10'h2AA, 10, 8'h00, 0, 0, -1);
    if (!held_m) run_frame("rst_addr2", 1'b1, 10'h2AA, 10, 8'h00, 0, 0, -1);
    run_frame("rst_data", 1'b1, 10'h35A, 10, 8'hC3, 14, 2, 17);
    run_frame("post_reset", 1'b1, 10'h3E1, 10, 8'hF0, 13, 2, -1);
  endtask

  task automatic test_random();
    logic       cmd;
    logic [9:0] word;
    int         nbits, ts, tl;
    for (int n = 0; n < 14; n++) begin
      cmd  = 1'($urandom_range(0, 1));
      word = 10'($urandom);
      if (cmd && $urandom_range(0, 3) != 0) word[9] = 1'b1;
      nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : 10;
      ts    = $urandom_range(6, 20);
      tl    = (nbits == 10) ? $urandom_range(1, 25) : 0;
      run_frame("random", cmd, word, nbits, 8'($urandom), ts, tl, -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_held_tx();
    test_abort();
    test_opcode();
    test_reset_mid_tx();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
